micro_secuenciador: RTL and testbench

- Microprogram sequencer: the addressing side of the microprogrammed machine. It drives the address bus of the asynchronous control-store ROM, samples the returned microword, and registers the control field for the datapath.
- Next address is computed from the current microword using these modes:
  - sequential;
  - unconditional jump;
  - conditional branch on datapath flags;
  - dispatch from an external mapping address.
- A start/finish handshake frames each microroutine.

---
 rtl/micro_secuenciador.sv | 157 +++++++++++++++
 tb/tb_micro_secuenciador.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_secuenciador.sv
// Microprogram sequencer: uPC drives async control-store ROM, next address from CONT/FIN/SALTO/COND/MAP, registered control field.
// Start latency 2 cycles to first control word; espera stalls everything in EJECUTA; MICRO_PILA_EN adds a 4-deep CALL/RET stack.
module micro_secuenciador #(
    parameter int ANCHO     = 20,
    parameter int ANCHO_DIR = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        inicio,
    input  logic                        espera,
    input  logic [2:0]                  cond,
    input  logic [ANCHO_DIR-1:0]        dir_map,
    output logic [ANCHO_DIR-1:0]        rom_dir,
    input  logic [ANCHO-1:0]            rom_dato,
    output logic [ANCHO-5-ANCHO_DIR:0]  control,
    output logic                        ocupado,
    output logic                        listo,
    output logic                        error_pila
);
    localparam int CW = ANCHO - 4 - ANCHO_DIR;

    typedef enum logic {INACTIVO, EJECUTA} estado_t;

    estado_t              estado;
    logic                 arranque;
    logic [ANCHO_DIR-1:0] upc;
    logic [ANCHO_DIR-1:0] upc_inc;
    logic [ANCHO_DIR-1:0] siguiente;
    logic [1:0]           modo;
    logic [1:0]           sel;
    logic [ANCHO_DIR-1:0] dir;
    logic [CW-1:0]        ctrl;
    logic                 cond_ok;
    logic                 es_fin;

    assign modo    = rom_dato[ANCHO-1:ANCHO-2];
    assign sel     = rom_dato[ANCHO-3:ANCHO-4];
    assign dir     = rom_dato[ANCHO-5 -: ANCHO_DIR];
    assign ctrl    = rom_dato[CW-1:0];
    assign upc_inc = upc + ANCHO_DIR'(1);
    assign rom_dir = upc;

`ifdef MICRO_PILA_EN
    logic [ANCHO_DIR-1:0] pila [4];
    logic [2:0]           sp;
    logic [2:0]           sp_m1;
    logic                 push;
    logic                 pop;
    logic                 avanza;
    logic                 err_q;

    assign sp_m1      = sp - 3'd1;
    assign avanza     = (estado == EJECUTA) && !espera;
    assign error_pila = err_q;
`else
    assign error_pila = 1'b0;
`endif

    always_comb begin
        case (sel)
            2'b00:   cond_ok = cond[0];
            2'b01:   cond_ok = cond[1];
            2'b10:   cond_ok = cond[2];
            default: cond_ok = !cond[0];
        endcase
    end

    always_comb begin
        siguiente = upc_inc;
        es_fin    = 1'b0;
`ifdef MICRO_PILA_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        case (modo)
            2'b00: es_fin = (sel == 2'b11);
            2'b01: begin
                siguiente = dir;
`ifdef MICRO_PILA_EN
                if (sel == 2'b01) begin
                    push = 1'b1;
                end else if (sel == 2'b10) begin
                    pop       = 1'b1;
                    // Underflow returns to the routine entry point.
                    siguiente = (sp == 3'd0) ? '0 : pila[sp_m1[1:0]];
                end
`endif
            end
            2'b10: if (cond_ok) siguiente = dir;
            default: siguiente = dir_map;
        endcase
    end

    // The start request is captured first, so state changes one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= INACTIVO;
            arranque <= 1'b0;
            upc      <= '0;
            control  <= '0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                INACTIVO: begin
                    if (arranque) begin
                        estado   <= EJECUTA;
                        ocupado  <= 1'b1;
                        arranque <= 1'b0;
                    end else begin
                        arranque <= inicio;
                    end
                end
                default: begin
                    if (!espera) begin
                        if (es_fin) begin
                            estado  <= INACTIVO;
                            ocupado <= 1'b0;
                            upc     <= '0;
                            control <= '0;
                            listo   <= 1'b1;
                        end else begin
                            upc     <= siguiente;
                            control <= ctrl;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MICRO_PILA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < 4; i++) pila[i] <= '0;
        end else if (avanza) begin
            if (es_fin) begin
                sp <= '0;
            end else if (push) begin
                if (sp == 3'd4) begin
                    err_q <= 1'b1;
                end else begin
                    pila[sp[1:0]] <= upc_inc;
                    sp            <= sp + 3'd1;
                end
            end else if (pop) begin
                if (sp == 3'd0) err_q <= 1'b1;
                else            sp    <= sp_m1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_micro_secuenciador.sv
// Directed bench for micro_secuenciador (ANCHO=20, ANCHO_DIR=8); stack scenarios need MICRO_PILA_EN.
module tb_micro_secuenciador;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic        espera = 1'b0;
    logic [2:0]  cond = 3'b000;
    logic [7:0]  dir_map = 8'h00;
    logic [7:0]  rom_dir;
    logic [19:0] rom_dato;
    logic [7:0]  control;
    logic        ocupado;
    logic        listo;
    logic        error_pila;

    logic [19:0] rom [256];
    int total = 0;
    int bad = 0;

    localparam logic [19:0] FIN = 20'h30000;

    micro_secuenciador #(.ANCHO(20), .ANCHO_DIR(8)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .espera(espera),
        .cond(cond), .dir_map(dir_map), .rom_dir(rom_dir), .rom_dato(rom_dato),
        .control(control), .ocupado(ocupado), .listo(listo), .error_pila(error_pila)
    );

    assign rom_dato = rom[rom_dir];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic borrar_rom();
        for (int i = 0; i < 256; i++) rom[i] = FIN;
    endtask

    task automatic reiniciar();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Edge k samples inicio, edge k+1 enters EJECUTA; the next edge fetches ROM[0].
    task automatic arrancar(input string tag);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        chk({tag, "_ocupado_k"}, ocupado, 0);
        chk({tag, "_listo_k"}, listo, 0);
        tick();
        chk({tag, "_ocupado_k1"}, ocupado, 1);
        chk({tag, "_dir_k1"}, rom_dir, 8'h00);
        chk({tag, "_ctrl_k1"}, control, 8'h00);
    endtask

    logic [19:0] t_word [7];
    logic [2:0]  t_cond [7];
    logic [7:0]  t_dest [7];

    initial begin
        borrar_rom();
        // Reset state
        tick();
        chk("rst_dir", rom_dir, 8'h00);
        chk("rst_ctrl", control, 8'h00);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_listo", listo, 0);
        chk("rst_err", error_pila, 0);
        rst_n = 1'b1;
        tick();

        // Sequential + FIN, then restart on the edge right after FIN
        rom[0] = 20'h00011; rom[1] = 20'h00022; rom[2] = FIN;
        arrancar("seq");
        tick(); chk("seq_ctrl0", control, 8'h11); chk("seq_dir0", rom_dir, 8'h01);
        tick(); chk("seq_ctrl1", control, 8'h22); chk("seq_dir1", rom_dir, 8'h02);
        tick();
        chk("seq_fin_ctrl", control, 8'h00);
        chk("seq_fin_listo", listo, 1);
        chk("seq_fin_ocupado", ocupado, 0);
        chk("seq_fin_dir", rom_dir, 8'h00);
        arrancar("seq_again");
        tick(); chk("seq2_ctrl0", control, 8'h11);
        tick(); tick();
        chk("seq2_listo", listo, 1);
        tick();
        chk("seq2_listo_pulse", listo, 0);

        // Jump to 0x40 then conditional branch to 0x50 (sel picks Z/N/C/!Z)
        t_word = '{20'h950BB, 20'h950BB, 20'h850BB, 20'h850BB, 20'hA50BB, 20'hB50BB, 20'hB50BB};
        t_cond = '{3'b010,    3'b000,    3'b001,    3'b010,    3'b100,    3'b000,    3'b001};
        t_dest = '{8'h50,     8'h41,     8'h50,     8'h41,     8'h50,     8'h50,     8'h41};
        borrar_rom();
        rom[0] = 20'h440AA;
        for (int i = 0; i < 7; i++) begin
            rom[8'h40] = t_word[i];
            cond = t_cond[i];
            arrancar($sformatf("br%0d", i));
            tick();
            chk($sformatf("br%0d_jmp_dir", i), rom_dir, 8'h40);
            chk($sformatf("br%0d_jmp_ctrl", i), control, 8'hAA);
            tick();
            chk($sformatf("br%0d_dest", i), rom_dir, t_dest[i]);
            chk($sformatf("br%0d_ctrl", i), control, 8'hBB);
            tick();
            chk($sformatf("br%0d_listo", i), listo, 1);
        end
        cond = 3'b000;

        // Dispatch and wrap at 0xFF
        borrar_rom();
        rom[0] = 20'hC0033; rom[8'h7F] = 20'h4FF55; rom[8'hFF] = 20'h00044;
        dir_map = 8'h7F;
        arrancar("map");
        tick(); chk("map_dir", rom_dir, 8'h7F); chk("map_ctrl", control, 8'h33);
        tick(); chk("jmp_ff_dir", rom_dir, 8'hFF); chk("jmp_ff_ctrl", control, 8'h55);
        dir_map = 8'h30;
        tick(); chk("wrap_dir", rom_dir, 8'h00); chk("wrap_ctrl", control, 8'h44);
        tick(); chk("map2_dir", rom_dir, 8'h30);
        tick(); chk("map_listo", listo, 1);

        // Stall mid-routine, and stall holding a FIN word
        borrar_rom();
        for (int i = 0; i < 4; i++) rom[i] = 20'h00001 + 20'(i);
        arrancar("stall");
        tick(); chk("stall_pre_dir", rom_dir, 8'h01);
        espera = 1'b1;
        inicio = 1'b1;
        tick(); tick(); tick();
        inicio = 1'b0;
        chk("stall_dir", rom_dir, 8'h01);
        chk("stall_ctrl", control, 8'h01);
        chk("stall_ocupado", ocupado, 1);
        espera = 1'b0;
        tick(); chk("resume_dir", rom_dir, 8'h02); chk("resume_ctrl", control, 8'h02);
        tick(); tick(); chk("at_fin_dir", rom_dir, 8'h04);
        espera = 1'b1;
        tick();
        chk("stall_fin_ocupado", ocupado, 1);
        chk("stall_fin_listo", listo, 0);
        chk("stall_fin_dir", rom_dir, 8'h04);
        espera = 1'b0;
        tick(); chk("fin_after_stall_listo", listo, 1);

        // Asynchronous reset mid-routine
        arrancar("arst");
        tick(); tick();
        chk("arst_pre_ctrl", control, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", control, 8'h00);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_dir", rom_dir, 8'h00);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("arst_no_resume_ocupado", ocupado, 0);
        chk("arst_no_resume_dir", rom_dir, 8'h00);

`ifdef MICRO_PILA_EN
        // CALL at 0x10 to 0x80, RET back to 0x11
        borrar_rom();
        rom[0] = 20'h41000; rom[8'h10] = 20'h58000; rom[8'h80] = 20'h60000;
        arrancar("call");
        tick(); chk("call_at", rom_dir, 8'h10);
        tick(); chk("call_tgt", rom_dir, 8'h80);
        tick(); chk("ret_dir", rom_dir, 8'h11);
        tick(); chk("call_listo", listo, 1); chk("call_err", error_pila, 0);

        // Five nested CALLs overflow the 4-entry stack
        borrar_rom();
        for (int i = 0; i < 5; i++) rom[i] = 20'h50000 | (20'(i + 1) << 8);
        arrancar("ovf");
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ovf_dir%0d", i), rom_dir, 8'(i));
            chk($sformatf("ovf_err%0d", i), error_pila, 0);
        end
        tick(); chk("ovf_dir5", rom_dir, 8'h05); chk("ovf_err5", error_pila, 1);
        tick(); chk("ovf_listo", listo, 1); chk("ovf_sticky", error_pila, 1);
        reiniciar();
        chk("ovf_rst_err", error_pila, 0);

        // FIN empties the stack, so a later RET underflows to 0
        borrar_rom();
        rom[0] = 20'h50100;
        arrancar("push_fin");
        tick(); chk("push_fin_dir", rom_dir, 8'h01);
        tick(); chk("push_fin_listo", listo, 1);
        rom[0] = 20'h42000; rom[8'h20] = 20'h60000;
        arrancar("unf");
        tick(); chk("unf_pre", rom_dir, 8'h20);
        tick(); chk("unf_dir", rom_dir, 8'h00); chk("unf_err", error_pila, 1);
        chk("unf_ocupado", ocupado, 1);
        reiniciar();
`else
        // Without the stack, CALL/RET encodings are plain jumps
        borrar_rom();
        rom[0] = 20'h58000; rom[8'h80] = 20'h62000;
        arrancar("nostack");
        tick(); chk("nostack_call", rom_dir, 8'h80);
        tick(); chk("nostack_ret", rom_dir, 8'h20);
        tick(); chk("nostack_listo", listo, 1); chk("nostack_err", error_pila, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
